// File: rtl/top_pkg.sv
// top_pkg: shared defaults, keypad geometry and key-index type for the
// 16-step keypad sequencer.
package top_pkg;

    localparam int CLK_HZ      = 12000000;
    localparam int ROW_DWELL   = CLK_HZ / 1000;  // 1 ms per keypad row
    localparam int STEP_CYCLES = CLK_HZ / 8;     // 125 ms per sequencer step
    localparam int TONE_HALF   = CLK_HZ / 880;   // half period of 440 Hz

    localparam int NUM_ROWS  = 4;
    localparam int NUM_COLS  = 4;
    localparam int NUM_STEPS = 16;
    localparam int NUM_KEYS  = NUM_ROWS * NUM_COLS;

    typedef logic [$clog2(NUM_KEYS)-1:0] key_idx_t;

    // Key number as printed on the pad: row-major, four keys per row.
    function automatic key_idx_t key_index(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/top_if.sv
// top_if: keypad bus between the row scanner and its consumer.
// Rows and columns are active-low; pressed is one bit per key, 1 = held.
// The scanner (master) drives the rows and publishes the pressed vector;
// the board side (slave) returns the column levels.
interface top_if;
    import top_pkg::*;

    logic [NUM_ROWS-1:0] row_n;
    logic [NUM_COLS-1:0] col_n;
    logic [NUM_KEYS-1:0] pressed;

    modport master (output row_n, output pressed, input col_n);
    modport slave  (input row_n, input pressed, output col_n);

endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: walks one low row across the 4x4 pad, synchronises the
// columns through two flops and samples them on the last dwell cycle of
// each row, producing a 16-bit held-key vector.
// Build option: KEYPAD_DEBOUNCE_EN makes each key change state only after
// four consecutive samples disagree with its current state.
module keypad_scanner
    import top_pkg::*;
#(
    parameter int ROW_DWELL = top_pkg::ROW_DWELL
) (
    input  logic  clk,
    input  logic  rst_n,
    top_if.master kp
);

    localparam int            DW         = $clog2(ROW_DWELL + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);

    logic [DW-1:0]       dwell_q, dwell_d;
    logic [1:0]          row_q, row_d;
    logic [NUM_COLS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] pressed_q, pressed_d;
    logic                sample;
    key_idx_t            k;
`ifdef KEYPAD_DEBOUNCE_EN
    logic [1:0]          db_cnt_q [NUM_KEYS];
    logic [1:0]          db_cnt_d [NUM_KEYS];
`endif

    // Row dwell timing and per-key state update at the end of each dwell.
    always_comb begin
        dwell_d   = dwell_q + 1'b1;
        row_d     = row_q;
        pressed_d = pressed_q;
        k         = '0;
`ifdef KEYPAD_DEBOUNCE_EN
        db_cnt_d  = db_cnt_q;
`endif
        sample    = (dwell_q == DWELL_LAST);
        if (sample) begin
            dwell_d = '0;
            row_d   = row_q + 1'b1;
            for (int c = 0; c < NUM_COLS; c++) begin
                k = key_index(row_q, 2'(c));
`ifdef KEYPAD_DEBOUNCE_EN
                if ((~sync2_q[c]) != pressed_q[k]) begin
                    if (db_cnt_q[k] == 2'd3) begin
                        pressed_d[k] = ~pressed_q[k];
                        db_cnt_d[k]  = '0;
                    end else begin
                        db_cnt_d[k]  = db_cnt_q[k] + 1'b1;
                    end
                end else begin
                    db_cnt_d[k] = '0;
                end
`else
                pressed_d[k] = ~sync2_q[c];
`endif
            end
        end
    end

    // Scanner registers; columns idle high (released) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q   <= '0;
            row_q     <= '0;
            sync1_q   <= '1;
            sync2_q   <= '1;
            pressed_q <= '0;
`ifdef KEYPAD_DEBOUNCE_EN
            for (int i = 0; i < NUM_KEYS; i++) db_cnt_q[i] <= '0;
`endif
        end else begin
            dwell_q   <= dwell_d;
            row_q     <= row_d;
            sync1_q   <= kp.col_n;
            sync2_q   <= sync1_q;
            pressed_q <= pressed_d;
`ifdef KEYPAD_DEBOUNCE_EN
            db_cnt_q  <= db_cnt_d;
`endif
        end
    end

    assign kp.row_n   = ~(4'b0001 << row_q);
    assign kp.pressed = pressed_q;

endmodule

// File: rtl/top.sv
// top: 16-step keypad sequencer. Each newly pressed key flips its step in
// the pattern; the step counter plays a 440 Hz square wave on _44b for
// every armed step, flashes LED on each beat (steps 0/4/8/12) and shows
// status on the active-low RGB LED.
module top
    import top_pkg::*;
#(
    parameter int CLK_HZ      = top_pkg::CLK_HZ,
    parameter int ROW_DWELL   = CLK_HZ / 1000,
    parameter int STEP_CYCLES = CLK_HZ / 8,
    parameter int TONE_HALF   = CLK_HZ / 880
) (
    input  logic clk,
    input  logic rst_n,
    input  logic _39a,
    input  logic _38b,
    input  logic _41a,
    input  logic _42b,
    output logic _36b,
    output logic _37a,
    output logic _29b,
    output logic _31b,
    output logic _44b,
    output logic LED,
    output logic RGB_R,
    output logic RGB_G,
    output logic RGB_B
);

    localparam int            SW        = $clog2(STEP_CYCLES + 1);
    localparam int            TW        = $clog2(TONE_HALF + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0] BEAT_LEN  = SW'(STEP_CYCLES / 8);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

    top_if kp ();

    assign kp.col_n = {_42b, _41a, _38b, _39a};
    assign {_31b, _29b, _37a, _36b} = kp.row_n;

    keypad_scanner #(.ROW_DWELL(ROW_DWELL)) u_scanner (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    logic [SW-1:0]                  step_cnt_q, step_cnt_d;
    logic [$clog2(NUM_STEPS)-1:0]   step_q, step_d;
    logic [NUM_KEYS-1:0]            pattern_q, pattern_d;
    logic [NUM_KEYS-1:0]            prev_q, prev_d;
    logic [TW-1:0]                  tone_cnt_q, tone_cnt_d;
    logic                           tone_q, tone_d;
    logic                           step_wrap, en_now, en_next;

    // Step timing, press-edge toggling and the tone divider. The divider
    // restarts whenever a step begins or its step becomes armed, and is
    // held silent while the step (as it will be next cycle) is unarmed.
    always_comb begin
        step_wrap  = (step_cnt_q == STEP_LAST);
        step_cnt_d = step_wrap ? '0 : step_cnt_q + 1'b1;
        step_d     = step_wrap ? step_q + 1'b1 : step_q;
        prev_d     = kp.pressed;
        pattern_d  = pattern_q ^ (kp.pressed & ~prev_q);
        en_now     = pattern_q[step_q];
        en_next    = pattern_d[step_d];
        tone_cnt_d = tone_cnt_q + 1'b1;
        tone_d     = tone_q;
        if (step_wrap || !en_next || !en_now) begin
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end else if (tone_cnt_q == TONE_LAST) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= '0;
            step_q     <= '0;
            pattern_q  <= '0;
            prev_q     <= '0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else begin
            step_cnt_q <= step_cnt_d;
            step_q     <= step_d;
            pattern_q  <= pattern_d;
            prev_q     <= prev_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
        end
    end

    // Indicators are gated by rst_n so they drop to idle the moment reset asserts.
    assign _44b  = tone_q;
    assign LED   = rst_n & (step_q[1:0] == 2'b00) & (step_cnt_q < BEAT_LEN);
    assign RGB_R = ~(rst_n & pattern_q[step_q]);
    assign RGB_G = ~(rst_n & (step_q == '0));
    assign RGB_B = ~(rst_n & (|kp.pressed));

endmodule

// File: tb/tb_top.sv
// tb_top: directed bench for the keypad sequencer with short timing
// parameters. A keypad model answers the row drive; a cycle model derives
// rows, step, beat, tone and RGB from elapsed cycles and the key history.
module tb_top;

    localparam int RD = 4;     // row dwell
    localparam int SC = 1200;  // cycles per step
    localparam int TH = 10;    // tone half period

    logic        clk = 1'b0;
    logic        rst_n;
    logic        _36b, _37a, _29b, _31b;
    logic        _44b, LED, RGB_R, RGB_G, RGB_B;
    logic [15:0] key_held;

    int n        = 0;
    int n_checks = 0;
    int n_fail   = 0;

    top_if kp_bus ();

    always #5 clk = ~clk;

    top #(.CLK_HZ(12000000), .ROW_DWELL(RD), .STEP_CYCLES(SC), .TONE_HALF(TH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        ._39a  (kp_bus.col_n[0]),
        ._38b  (kp_bus.col_n[1]),
        ._41a  (kp_bus.col_n[2]),
        ._42b  (kp_bus.col_n[3]),
        ._36b  (_36b),
        ._37a  (_37a),
        ._29b  (_29b),
        ._31b  (_31b),
        ._44b  (_44b),
        .LED   (LED),
        .RGB_R (RGB_R),
        .RGB_G (RGB_G),
        .RGB_B (RGB_B)
    );

    assign kp_bus.row_n   = {_31b, _29b, _37a, _36b};
    assign kp_bus.pressed = key_held;

    // Keypad matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        kp_bus.col_n = 4'hf;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_held[r*4+c] && !kp_bus.row_n[r]) kp_bus.col_n[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
        end
    endtask

    // Advance to a given cycle index; leaves the caller just after that cycle's clock edge.
    task automatic goto_cycle(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 40000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (n != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL goto_cycle: reached %0d expected %0d", n, target);
        end
    endtask

    // Reference model state.
    logic [15:0] pat_vis, prs_vis, prs_next, rise_next, kh1, kh2;
    logic        prs_pend, en_prev, m_en;
    int          run_start, m_row, m_step, m_off;
    logic [8:0]  exp_v, act_v;

    // Compare process: one full output check per cycle out of reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            n         = 0;
            pat_vis   = '0;
            prs_vis   = '0;
            prs_next  = '0;
            rise_next = '0;
            prs_pend  = 1'b0;
            kh1       = '0;
            kh2       = '0;
            en_prev   = 1'b0;
            run_start = 0;
        end else begin
            // A key sample shows up one cycle later; its toggle one cycle after that.
            pat_vis   = pat_vis ^ rise_next;
            rise_next = '0;
            if (prs_pend) begin
                rise_next = prs_next & ~prs_vis;
                prs_vis   = prs_next;
                prs_pend  = 1'b0;
            end
            m_row  = (n / RD) % 4;
            m_step = (n / SC) % 16;
            m_off  = n % SC;
            m_en   = pat_vis[m_step];
            if (m_en && (m_off == 0 || !en_prev)) run_start = n;
            en_prev = m_en;
            exp_v = {~(4'b0001 << m_row),
                     m_en && (((n - run_start) / TH) % 2 == 1),
                     (m_step % 4 == 0) && (m_off < SC / 8),
                     !m_en,
                     m_step != 0,
                     prs_vis == 16'h0};
            act_v = {_31b, _29b, _37a, _36b, _44b, LED, RGB_R, RGB_G, RGB_B};
            check("outputs", act_v, exp_v);
            // Last dwell cycle: columns seen now left the keypad two cycles ago.
            if (n % RD == RD - 1) begin
                prs_next = prs_vis;
                for (int c = 0; c < 4; c++) prs_next[m_row*4+c] = kh2[m_row*4+c];
                prs_pend = 1'b1;
            end
            kh2 = kh1;
            kh1 = key_held;
            n++;
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    // Directed stimulus with hand-computed pins.
    initial begin
        rst_n    = 1'b0;
        key_held = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_rows", {_31b, _29b, _37a, _36b}, 4'b1110);
        check("rst_tone", _44b, 1'b0);
        check("rst_led", LED, 1'b0);
        check("rst_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
        @(posedge clk);
        #1 rst_n = 1'b1;

        goto_cycle(5);     check("row1_driven", {_31b, _29b, _37a, _36b}, 4'b1101);
        goto_cycle(10);    check("beat_step0", LED, 1'b1);
                           check("green_step0", RGB_G, 1'b0);
        goto_cycle(160);   check("beat_over", LED, 1'b0);
        goto_cycle(1210);  check("green_step1", RGB_G, 1'b1);

        // Keys 0 and 15 together, then key 5 twice, then key 10 held long.
        goto_cycle(2500);  key_held = 16'h8001;
        goto_cycle(2580);  check("blue_held", RGB_B, 1'b0);
        goto_cycle(2600);  key_held = 16'h0000;
        goto_cycle(2650);  check("blue_released", RGB_B, 1'b1);
        goto_cycle(2700);  key_held = 16'h0020;
        goto_cycle(2800);  key_held = 16'h0000;
        goto_cycle(2900);  key_held = 16'h0020;
        goto_cycle(3000);  key_held = 16'h0000;
        goto_cycle(3100);  key_held = 16'h0400;
        goto_cycle(3500);  key_held = 16'h0000;

        goto_cycle(4810);  check("beat_step4", LED, 1'b1);
        goto_cycle(6015);  check("tone_step5", _44b, 1'b0);
                           check("red_step5", RGB_R, 1'b1);
        goto_cycle(12005); check("tone_step10_low", _44b, 1'b0);
        goto_cycle(12015); check("tone_step10_high", _44b, 1'b1);
                           check("red_step10", RGB_R, 1'b0);
        goto_cycle(18035); check("tone_step15", _44b, 1'b1);
        goto_cycle(19215); check("tone_wrap_high", _44b, 1'b1);
                           check("beat_wrap", LED, 1'b1);
                           check("green_wrap", RGB_G, 1'b0);
        goto_cycle(19225); check("tone_wrap_low", _44b, 1'b0);
        goto_cycle(19719); check("tone_before_rst", _44b, 1'b1);

        // Reset mid-tone, between clock edges.
        #1 rst_n = 1'b0;
        #1;
        check("async_tone", _44b, 1'b0);
        check("async_led", LED, 1'b0);
        check("async_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
        check("async_rows", {_31b, _29b, _37a, _36b}, 4'b1110);
        repeat (4) @(posedge clk);
        #2 check("rst_hold_rows", {_31b, _29b, _37a, _36b}, 4'b1110);
        @(posedge clk);
        #1 rst_n = 1'b1;

        goto_cycle(15);    check("restart_tone", _44b, 1'b0);
                           check("restart_red", RGB_R, 1'b1);
                           check("restart_green", RGB_G, 1'b0);
        goto_cycle(1300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter CLK_HZ, default 12000000, input clock frequency in Hz.
REQ-002 Parameter ROW_DWELL, default 12000, clock cycles each keypad row is driven (1 ms).
REQ-003 Parameter STEP_CYCLES, default 1500000, clock cycles per sequencer step (125 ms).
REQ-004 Parameter TONE_HALF, default 13636, clock cycles per tone half-period (440 Hz).
REQ-005 Port clk, input, 1, system clock; all logic SHALL be in this single domain.
REQ-006 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 Ports _39a, _38b, _41a, _42b, input, 1 each, keypad columns 0..3, pulled up externally, low = key pressed.
REQ-008 Ports _36b, _37a, _29b, _31b, output, 1 each, keypad rows 0..3, active-low drive.
REQ-009 Port _44b, output, 1, audio square-wave output.
REQ-010 Port LED, output, 1, beat indicator, active-high.
REQ-011 Ports RGB_R, RGB_G, RGB_B, output, 1 each, status LED, active-low.

Function
REQ-012 Scanner SHALL drive exactly one row low and the other three high, cycling rows 0->1->2->3->0, ROW_DWELL cycles per row.
REQ-013 Column inputs SHALL pass a 2-flop synchronizer; columns SHALL be sampled on the last cycle of each row dwell.
REQ-014 Key index SHALL be row*4+col (0..15); a key is pressed when its column samples low while its row is driven.
REQ-015 A released->pressed transition of key k SHALL toggle bit k of a 16-bit pattern register exactly once; a held key SHALL NOT retoggle.
REQ-016 Keys pressed simultaneously SHALL each toggle independently.
REQ-017 Step counter (4 bits) SHALL advance every STEP_CYCLES cycles and wrap 15->0.
REQ-018 _44b SHALL toggle every TONE_HALF cycles while pattern[step]=1, else SHALL be 0; the tone divider SHALL restart at each step boundary.
REQ-019 If a toggle and a step advance coincide, the toggle SHALL apply, and _44b SHALL follow the updated pattern bit from the next cycle.
REQ-020 LED SHALL be 1 during the first STEP_CYCLES/8 cycles of steps 0, 4, 8 and 12, else 0.
REQ-021 RGB_R SHALL be 0 (lit) while pattern[step]=1; RGB_G SHALL be 0 while step==0; RGB_B SHALL be 0 while any key is registered pressed.

Reset
REQ-022 While rst_n=0: pattern=0, step=0, all dividers=0, key states=released, row 0 driven low (_36b=0, others 1), _44b=0, LED=0, RGB_R/G/B=1.
REQ-023 Reset asserted mid-step or mid-scan SHALL take effect immediately; after release, operation SHALL restart from step 0, row 0.

Configuration
REQ-024 Macro KEYPAD_DEBOUNCE_EN defined: a key state SHALL change only after 4 consecutive identical samples of that key (about 16 ms at defaults).
REQ-025 KEYPAD_DEBOUNCE_EN undefined: each sample SHALL update key state directly.

Structure
REQ-026 A shared package top_pkg SHALL hold the default constants (CLK_HZ, ROW_DWELL, STEP_CYCLES, TONE_HALF), NUM_ROWS=4, NUM_COLS=4, NUM_STEPS=16, and a key-index type.
REQ-027 Keypad scanning, synchronization and debounce SHALL be a sub-module keypad_scanner that outputs a 16-bit pressed vector; the sequencer, tone, LED and RGB logic SHALL reside in top.

Verification
REQ-028 All columns 1 for 1.2 s at defaults -> _44b stays 0, RGB_R stays 1, LED pulses high for 15.625 ms at t=0, 500 ms and 1000 ms, RGB_G low only during 0-125 ms.
REQ-029 Drive _39a low only while _36b=0, for 30 ms -> pattern bit 0 set, RGB_B low during the press, exactly one toggle occurs.
REQ-030 Set pattern bit 0 and run with STEP_CYCLES=1200 and TONE_HALF=10 -> _44b toggles every 10 cycles during step 0 only, and repeats after wrap 15->0.
REQ-031 Press the same key twice (press, release, press) -> pattern bit returns to 0; a press-and-hold of 100 ms -> single toggle.
REQ-032 Press _42b with row 3 (_31b) and _39a with row 0 concurrently -> bits 15 and 0 both set.
REQ-033 Assert rst_n=0 mid-tone -> _44b, LED, pattern and step reach 0 and RGB reaches 111 asynchronously; rows return to _36b=0.
